sfp_link_ctrl: RTL and testbench

//   Sequences the optical link: SFP transmitter enable, LVDS driver/receiver enables,

---
 rtl/sfp_link_pkg.sv | 25 ++
 rtl/sfp_link_ctrl_sync2.sv | 22 ++
 rtl/sfp_link_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_sfp_link_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sfp_link_pkg.sv
// Shared types for the optical link controller: FSM state encoding,
// fault cause codes and the width of the shared state timer.
package sfp_link_pkg;

    // Shared down-counter width; 20 bits covers the 400000-cycle timers.
    localparam int TMR_W = 20;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_SETTLE,
        ST_ACQ,
        ST_UP,
        ST_BACKOFF
    } state_t;

    typedef enum logic [2:0] {
        FLT_NONE   = 3'd0,
        FLT_TX     = 3'd1,
        FLT_LOS    = 3'd2,
        FLT_GAP    = 3'd3,
        FLT_RX_ERR = 3'd4,
        FLT_ACQ_TO = 3'd5
    } fault_t;

endpackage

// File: rtl/sfp_link_ctrl_sync2.sv
// Two-flop synchronizer for asynchronous SFP status pins.
// Ports: i_clk, i_res (sync, active high), i_d (async in), o_q (synced out).
module sync2 (
    input  logic i_clk,
    input  logic i_res,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] r_ff;

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_ff <= 2'b00;
        end else begin
            r_ff <= {r_ff[0], i_d};
        end
    end

    assign o_q = r_ff[1];

endmodule

// File: rtl/sfp_link_ctrl.sv
// Optical link sequencer: SFP TX enable, LVDS enables, link acquisition
// from received frame status, supervision with retry backoff.
// Ports: i_clk, i_res (sync, active high), i_enable, i_sfp_tx_flt, i_sfp_los,
//   i_rx_frame_ok, i_rx_frame_err -> o_sfp_tx_dis_n, o_drv_en, o_rcv_en_n,
//   o_tx_gate, o_link_up, o_fault_code[2:0], o_retry_cnt[7:0].
module sfp_link_ctrl
    import sfp_link_pkg::*;
#(
    parameter int SETTLE_CYC      = 40000,
    parameter int ACQ_TIMEOUT_CYC = 400000,
    parameter int RX_GAP_CYC      = 4000,
    parameter int GOOD_FRAMES     = 8,
    parameter int ERR_LIMIT       = 4,
    parameter int BACKOFF_CYC     = 400000
) (
    input  logic       i_clk,
    input  logic       i_res,
    input  logic       i_enable,
    input  logic       i_sfp_tx_flt,
    input  logic       i_sfp_los,
    input  logic       i_rx_frame_ok,
    input  logic       i_rx_frame_err,
    output logic       o_sfp_tx_dis_n,
    output logic       o_drv_en,
    output logic       o_rcv_en_n,
    output logic       o_tx_gate,
    output logic       o_link_up,
    output logic [2:0] o_fault_code,
    output logic [7:0] o_retry_cnt
);

    localparam int GW = $clog2(GOOD_FRAMES + 1);
    localparam int EW = $clog2(ERR_LIMIT + 1);

    // Timers load N-1 and transition when they read 0: N cycles in state.
    localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] ACQ_LD    = TMR_W'(ACQ_TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0] BO_LD     = TMR_W'(BACKOFF_CYC - 1);
    localparam logic [TMR_W-1:0] GAP_LIM   = TMR_W'(RX_GAP_CYC);
    localparam logic [GW-1:0]    GOOD_LAST = GW'(GOOD_FRAMES - 1);
    localparam logic [EW-1:0]    ERR_LAST  = EW'(ERR_LIMIT - 1);

    logic w_tflt_s;
    logic w_los_s;

    sync2 u_sync_tflt (
        .i_clk (i_clk),
        .i_res (i_res),
        .i_d   (i_sfp_tx_flt),
        .o_q   (w_tflt_s)
    );

    sync2 u_sync_los (
        .i_clk (i_clk),
        .i_res (i_res),
        .i_d   (i_sfp_los),
        .o_q   (w_los_s)
    );

    state_t           r_state;
    fault_t           r_code;
    logic [TMR_W-1:0] r_tmr;
    logic [TMR_W-1:0] r_gap;
    logic [GW-1:0]    r_good;
    logic [EW-1:0]    r_err;
    logic [7:0]       r_retry;
    logic             r_tx_dis_n;
    logic             r_drv_en;
    logic             r_rcv_en_n;
    logic             r_tx_gate;
    logic             r_link_up;

    // A simultaneous ok+err pulse counts as an error only.
    logic w_ok;
    logic w_err;
    logic w_frame;
    logic w_tmr_done;
    logic w_gap_to;

    assign w_ok       = i_rx_frame_ok & ~i_rx_frame_err;
    assign w_err      = i_rx_frame_err;
    assign w_frame    = i_rx_frame_ok | i_rx_frame_err;
    assign w_tmr_done = (r_tmr == '0);
    assign w_gap_to   = (r_gap > GAP_LIM);

    state_t           w_nxt;
    fault_t           w_code;
    logic [GW-1:0]    w_good_nxt;
    logic [EW-1:0]    w_err_nxt;
    logic [TMR_W-1:0] w_reload;
    logic             w_enter;
    logic             w_on;

    always_comb begin
        w_nxt      = r_state;
        w_code     = r_code;
        w_good_nxt = r_good;
        w_err_nxt  = r_err;
        if (!i_enable) begin
            w_nxt = ST_OFF;
        end else begin
            unique case (r_state)
                ST_OFF: begin
                    w_nxt = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (w_tflt_s) begin
                        w_nxt  = ST_BACKOFF;
                        w_code = FLT_TX;
                    end else if (w_tmr_done) begin
                        w_nxt = ST_ACQ;
                    end
                end
                ST_ACQ: begin
                    if (w_tflt_s) begin
                        w_nxt  = ST_BACKOFF;
                        w_code = FLT_TX;
                    end else if (w_tmr_done) begin
                        w_nxt  = ST_BACKOFF;
                        w_code = FLT_ACQ_TO;
                    end else if (w_los_s || w_gap_to || w_err) begin
                        w_good_nxt = '0;
                    end else if (w_ok) begin
                        if (r_good == GOOD_LAST) begin
                            w_nxt  = ST_UP;
                            w_code = FLT_NONE;
                        end else begin
                            w_good_nxt = r_good + 1'b1;
                        end
                    end
                end
                ST_UP: begin
                    if (w_tflt_s) begin
                        w_nxt  = ST_BACKOFF;
                        w_code = FLT_TX;
                    end else if (w_los_s) begin
                        w_nxt  = ST_BACKOFF;
                        w_code = FLT_LOS;
                    end else if (w_gap_to) begin
                        w_nxt  = ST_BACKOFF;
                        w_code = FLT_GAP;
                    end else if (w_err) begin
                        if (r_err == ERR_LAST) begin
                            w_nxt  = ST_BACKOFF;
                            w_code = FLT_RX_ERR;
                        end else begin
                            w_err_nxt = r_err + 1'b1;
                        end
                    end else if (w_ok) begin
                        w_err_nxt = '0;
                    end
                end
                ST_BACKOFF: begin
                    if (w_tmr_done) begin
                        w_nxt = ST_SETTLE;
                    end
                end
                default: begin
                    w_nxt = ST_OFF;
                end
            endcase
        end
    end

    always_comb begin
        w_reload = '0;
        unique case (w_nxt)
            ST_SETTLE:  w_reload = SETTLE_LD;
            ST_ACQ:     w_reload = ACQ_LD;
            ST_BACKOFF: w_reload = BO_LD;
            default:    w_reload = '0;
        endcase
    end

    assign w_enter = (w_nxt != r_state);
    assign w_on    = (r_state == ST_SETTLE) ||
                     (r_state == ST_ACQ) ||
                     (r_state == ST_UP);

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_state    <= ST_OFF;
            r_code     <= FLT_NONE;
            r_tmr      <= '0;
            r_gap      <= '0;
            r_good     <= '0;
            r_err      <= '0;
            r_retry    <= '0;
            r_tx_dis_n <= 1'b0;
            r_drv_en   <= 1'b0;
            r_rcv_en_n <= 1'b1;
            r_tx_gate  <= 1'b0;
            r_link_up  <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_code  <= w_code;
            if (w_enter) begin
                r_tmr  <= w_reload;
                r_gap  <= '0;
                r_good <= '0;
                r_err  <= '0;
                if (w_nxt == ST_BACKOFF && r_retry != 8'hFF) begin
                    r_retry <= r_retry + 8'd1;
                end
            end else begin
                if (!w_tmr_done) begin
                    r_tmr <= r_tmr - 1'b1;
                end
                if (w_frame) begin
                    r_gap <= '0;
                end else if (r_gap != '1) begin
                    r_gap <= r_gap + 1'b1;
                end
                r_good <= w_good_nxt;
                r_err  <= w_err_nxt;
            end
            // Outputs decode the current state, so they trail entry by a cycle.
            r_tx_dis_n <= w_on;
            r_drv_en   <= w_on;
            r_rcv_en_n <= ~w_on;
            r_tx_gate  <= (r_state == ST_UP);
            r_link_up  <= (r_state == ST_UP);
        end
    end

    assign o_sfp_tx_dis_n = r_tx_dis_n;
    assign o_drv_en       = r_drv_en;
    assign o_rcv_en_n     = r_rcv_en_n;
    assign o_tx_gate      = r_tx_gate;
    assign o_link_up      = r_link_up;
    assign o_fault_code   = r_code;
    assign o_retry_cnt    = r_retry;

endmodule

// File: tb/tb_sfp_link_ctrl.sv
// Self-checking bench for sfp_link_ctrl with shortened timer parameters.
// Directed sequence plus randomized acquisition rounds against a run-length model.
module tb_sfp_link_ctrl;

    localparam int GOOD = 3;

    logic       clk = 1'b0;
    logic       res;
    logic       en;
    logic       tflt;
    logic       los;
    logic       fok;
    logic       ferr;
    logic       tx_dis_n;
    logic       drv_en;
    logic       rcv_en_n;
    logic       tx_gate;
    logic       link_up;
    logic [2:0] code;
    logic [7:0] retry;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_retry = 0;
    bit evq[$];

    sfp_link_ctrl #(
        .SETTLE_CYC      (10),
        .ACQ_TIMEOUT_CYC (200),
        .RX_GAP_CYC      (20),
        .GOOD_FRAMES     (GOOD),
        .ERR_LIMIT       (2),
        .BACKOFF_CYC     (50)
    ) dut (
        .i_clk          (clk),
        .i_res          (res),
        .i_enable       (en),
        .i_sfp_tx_flt   (tflt),
        .i_sfp_los      (los),
        .i_rx_frame_ok  (fok),
        .i_rx_frame_err (ferr),
        .o_sfp_tx_dis_n (tx_dis_n),
        .o_drv_en       (drv_en),
        .o_rcv_en_n     (rcv_en_n),
        .o_tx_gate      (tx_gate),
        .o_link_up      (link_up),
        .o_fault_code   (code),
        .o_retry_cnt    (retry)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic logic pick(input int sel);
        return (sel == 0) ? link_up : tx_dis_n;
    endfunction

    // Bounded wait for link_up (sel 0) or tx_dis_n (sel 1) to reach val.
    task automatic wait_sig(input string tag, input int sel,
                            input logic val, input int max);
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (pick(sel) === val) break;
        end
        chk(tag, 32'(pick(sel)), 32'(val));
    endtask

    task automatic frame(input bit ok, input int idle);
        if (ok) fok = 1'b1;
        else ferr = 1'b1;
        @(negedge clk);
        fok  = 1'b0;
        ferr = 1'b0;
        repeat (idle) @(negedge clk);
    endtask

    // Wait for the transmitter to come on, then past the settle time.
    task automatic goto_acq(input string tag);
        wait_sig(tag, 1, 1'b1, 80);
        repeat (13) @(negedge clk);
    endtask

    // Link comes up on the frame that completes GOOD consecutive oks.
    task automatic run_evq(input string tag, input int sp);
        int run;
        bit up;
        int idle;
        run = 0;
        up  = 1'b0;
        foreach (evq[i]) begin
            if (up) break;
            idle = (sp == 0) ? int'($urandom_range(2, 8)) : sp;
            frame(evq[i], idle);
            run = evq[i] ? run + 1 : 0;
            if (run == GOOD) up = 1'b1;
            chk($sformatf("%s_ev%0d", tag, i), 32'(link_up), 32'(up));
        end
    endtask

    initial begin
        res  = 1'b1;
        en   = 1'b0;
        tflt = 1'b0;
        los  = 1'b0;
        fok  = 1'b0;
        ferr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_txdis", 32'(tx_dis_n), 0);
        chk("rst_drv", 32'(drv_en), 0);
        chk("rst_rcv", 32'(rcv_en_n), 1);
        chk("rst_gate", 32'(tx_gate), 0);
        chk("rst_up", 32'(link_up), 0);
        chk("rst_code", 32'(code), 0);
        chk("rst_retry", 32'(retry), 0);
        res = 1'b0;
        repeat (3) @(negedge clk);
        chk("off_idle_txdis", 32'(tx_dis_n), 0);

        en = 1'b1;
        goto_acq("s1_settle");
        chk("s1_drv", 32'(drv_en), 1);
        chk("s1_rcv", 32'(rcv_en_n), 0);
        evq = '{1'b1, 1'b1, 1'b1};
        run_evq("s1", 4);
        chk("s1_gate", 32'(tx_gate), 1);
        chk("s1_code", 32'(code), 0);
        chk("s1_retry", 32'(retry), 0);

        los = 1'b1;
        wait_sig("s2_down", 0, 1'b0, 6);
        exp_retry++;
        chk("s2_txdis", 32'(tx_dis_n), 0);
        chk("s2_gate", 32'(tx_gate), 0);
        chk("s2_code", 32'(code), 2);
        chk("s2_retry", 32'(retry), 32'(exp_retry));
        los = 1'b0;
        repeat (45) @(negedge clk);
        chk("s2_backoff_hold", 32'(tx_dis_n), 0);
        wait_sig("s2_resettle", 1, 1'b1, 10);

        goto_acq("s3_settle");
        evq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        run_evq("s3", 0);

        repeat (8) @(negedge clk);
        chk("s4_gap_hold", 32'(link_up), 1);
        wait_sig("s4_gap_down", 0, 1'b0, 20);
        exp_retry++;
        chk("s4_code", 32'(code), 3);
        chk("s4_retry", 32'(retry), 32'(exp_retry));

        goto_acq("s4b_settle");
        evq = '{1'b1, 1'b1, 1'b1};
        run_evq("s4b", 3);
        frame(1'b1, 20);
        frame(1'b1, 20);
        chk("s4b_gap20_up", 32'(link_up), 1);
        frame(1'b0, 3);
        frame(1'b1, 3);
        frame(1'b0, 3);
        chk("s4b_err_cleared", 32'(link_up), 1);
        frame(1'b0, 0);
        wait_sig("s4b_down", 0, 1'b0, 4);
        exp_retry++;
        chk("s4b_code", 32'(code), 4);
        chk("s4b_retry", 32'(retry), 32'(exp_retry));

        for (int r = 0; r < 4; r++) begin
            goto_acq($sformatf("rnd%0d_settle", r));
            evq.delete();
            for (int k = 0; k < 5; k++) begin
                evq.push_back($urandom_range(0, 99) < 65);
            end
            evq.push_back(1'b1);
            evq.push_back(1'b1);
            evq.push_back(1'b1);
            run_evq($sformatf("rnd%0d", r), 0);
            en = 1'b0;
            repeat (4) @(negedge clk);
            chk($sformatf("rnd%0d_off_up", r), 32'(link_up), 0);
            chk($sformatf("rnd%0d_off_tx", r), 32'(tx_dis_n), 0);
            chk($sformatf("rnd%0d_retry", r), 32'(retry), 32'(exp_retry));
            chk($sformatf("rnd%0d_code", r), 32'(code), 0);
            en = 1'b1;
        end

        goto_acq("s5_settle");
        repeat (150) @(negedge clk);
        chk("s5_acq_hold", 32'(tx_dis_n), 1);
        wait_sig("s5_timeout", 1, 1'b0, 80);
        exp_retry++;
        chk("s5_code", 32'(code), 5);
        chk("s5_retry", 32'(retry), 32'(exp_retry));

        en = 1'b0;
        repeat (60) @(negedge clk);
        chk("s6_off_retry", 32'(retry), 32'(exp_retry));
        chk("s6_off_code", 32'(code), 5);
        chk("s6_off_tx", 32'(tx_dis_n), 0);
        en = 1'b1;
        wait_sig("s6_settle", 1, 1'b1, 6);
        repeat (2) @(negedge clk);
        tflt = 1'b1;
        wait_sig("s6_tflt_down", 1, 1'b0, 8);
        tflt = 1'b0;
        exp_retry++;
        chk("s6_code", 32'(code), 1);
        chk("s6_retry", 32'(retry), 32'(exp_retry));
        repeat (3) @(negedge clk);
        en = 1'b0;
        repeat (60) @(negedge clk);
        chk("s6_bo_off_retry", 32'(retry), 32'(exp_retry));
        chk("s6_bo_off_tx", 32'(tx_dis_n), 0);

        tflt = 1'b1;
        en   = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (retry == 8'd255) break;
        end
        chk("s7_sat", 32'(retry), 255);
        repeat (200) @(negedge clk);
        chk("s7_sat_hold", 32'(retry), 255);
        chk("s7_code", 32'(code), 1);

        tflt = 1'b0;
        wait_sig("s8_pre", 1, 1'b1, 80);
        res = 1'b1;
        @(negedge clk);
        chk("s8_txdis", 32'(tx_dis_n), 0);
        chk("s8_drv", 32'(drv_en), 0);
        chk("s8_rcv", 32'(rcv_en_n), 1);
        chk("s8_retry", 32'(retry), 0);
        chk("s8_code", 32'(code), 0);
        res = 1'b0;
        en  = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
